itf_dram_initiator: RTL and testbench

Chip-side master of the off-chip DRAM port. It serialises internal read/write requests into the port protocol: a command beat first, then a burst of data beats. It also owns the direction control O_DatOE. Tristate merging of the O_Pad*/I_Pad* pairs onto the IO_* pins happens in TOP, outside this block.

---
 rtl/itf_pkg.sv | 36 +++
 rtl/itf_dram_initiator.sv | 140 ++++++++++++++
 tb/tb_itf_dram_initiator.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/itf_pkg.sv
// rtl/itf_pkg.sv - shared states, command-field offsets and command packing for the DRAM initiator
package itf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RD,
    S_WR,
    S_FNH
  } state_t;

  localparam int DEF_DRAM_ADDR_WIDTH = 32;
  localparam int CMD_MAX_WIDTH       = 256;
  localparam int CMD_WR_BIT          = 0;
  localparam int CMD_ADDR_LSB        = 1;
  localparam int CMD_NUM_LSB         = 1 + DEF_DRAM_ADDR_WIDTH;

  function automatic int cmd_num_lsb(input int dram_addr_width);
    return 1 + dram_addr_width;
  endfunction

  // Callers pass zero-extended fields; the result is wider than any port and is trimmed at the use site.
  function automatic logic [CMD_MAX_WIDTH-1:0] pack_cmd(
    input logic        wr,
    input logic [63:0] addr,
    input logic [63:0] num,
    input int          dram_addr_width
  );
    logic [CMD_MAX_WIDTH-1:0] cmd;
    cmd = CMD_MAX_WIDTH'(wr) << CMD_WR_BIT;
    cmd = cmd | (CMD_MAX_WIDTH'(addr) << CMD_ADDR_LSB);
    cmd = cmd | (CMD_MAX_WIDTH'(num) << cmd_num_lsb(dram_addr_width));
    return cmd;
  endfunction

endpackage

// File: rtl/itf_dram_initiator.sv
// rtl/itf_dram_initiator.sv - chip-side DRAM port master: command beat, data burst, direction control
module itf_dram_initiator
  import itf_pkg::*;
#(
  parameter int PORT_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 16,
  parameter int DRAM_ADDR_WIDTH = 32
) (
  input  logic                       I_SysClk,
  input  logic                       I_SysRst_n,
  input  logic                       I_ReqVld,
  input  logic                       I_ReqWr,
  input  logic [DRAM_ADDR_WIDTH-1:0] I_ReqAddr,
  input  logic [ADDR_WIDTH-1:0]      I_ReqNum,
  output logic                       O_ReqRdy,
  output logic                       O_ReqDone,
  input  logic [PORT_WIDTH-1:0]      I_WrDat,
  input  logic                       I_WrDatVld,
  output logic                       O_WrDatRdy,
  output logic [PORT_WIDTH-1:0]      O_RdDat,
  output logic                       O_RdDatVld,
  output logic                       O_RdDatLast,
  input  logic                       I_RdDatRdy,
  output logic                       O_DatOE,
  output logic [PORT_WIDTH-1:0]      O_PadDat,
  output logic                       O_PadDatVld,
  output logic                       O_PadDatLast,
  input  logic [PORT_WIDTH-1:0]      I_PadDat,
  input  logic                       I_PadDatVld,
  input  logic                       I_PadDatLast,
  output logic                       O_PadDatRdy,
  input  logic                       I_PadDatRdy,
  output logic                       O_LastErr
);

  state_t                     state, state_nxt;
  logic                       req_wr;
  logic [DRAM_ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0]      req_num;
  logic [ADDR_WIDTH-1:0]      cnt;
  logic [ADDR_WIDTH-1:0]      last_idx;
  logic                       cnt_last;
  logic                       accept;
  logic                       wr_beat;
  logic                       rd_beat;
  logic                       dat_oe;
  logic                       last_err;
  logic [PORT_WIDTH-1:0]      cmd_word;

  assign last_idx = req_num - ADDR_WIDTH'(1);
  assign cnt_last = (cnt == last_idx);
  assign accept   = (state == S_IDLE) && I_ReqVld;
  assign wr_beat  = (state == S_WR) && I_WrDatVld && I_PadDatRdy;
  assign rd_beat  = (state == S_RD) && I_PadDatVld && I_RdDatRdy;
  assign cmd_word = PORT_WIDTH'(pack_cmd(req_wr, 64'(req_addr), 64'(req_num), DRAM_ADDR_WIDTH));

  assign O_DatOE   = dat_oe;
  assign O_LastErr = last_err;

  always_ff @(posedge I_SysClk or negedge I_SysRst_n) begin
    if (!I_SysRst_n) begin
      state    <= S_IDLE;
      req_wr   <= 1'b0;
      req_addr <= '0;
      req_num  <= '0;
      cnt      <= '0;
      dat_oe   <= 1'b1;
      last_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Registered from the next state so the pads turn around on the same edge as the state change.
      dat_oe <= (state_nxt != S_RD);
      if (accept) begin
        req_wr   <= I_ReqWr;
        req_addr <= I_ReqAddr;
        req_num  <= I_ReqNum;
        cnt      <= '0;
      end else if (wr_beat || rd_beat) begin
        cnt <= cnt + ADDR_WIDTH'(1);
      end
      if (rd_beat && (I_PadDatLast != cnt_last)) begin
        last_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    O_ReqRdy     = 1'b0;
    O_ReqDone    = 1'b0;
    O_WrDatRdy   = 1'b0;
    O_RdDat      = '0;
    O_RdDatVld   = 1'b0;
    O_RdDatLast  = 1'b0;
    O_PadDat     = '0;
    O_PadDatVld  = 1'b0;
    O_PadDatLast = 1'b0;
    O_PadDatRdy  = 1'b0;
    case (state)
      S_IDLE: begin
        O_ReqRdy = 1'b1;
        if (I_ReqVld) begin
          state_nxt = (I_ReqNum == '0) ? S_FNH : S_CMD;
        end
      end
      S_CMD: begin
        O_PadDat    = cmd_word;
        O_PadDatVld = 1'b1;
        if (I_PadDatRdy) begin
          state_nxt = req_wr ? S_WR : S_RD;
        end
      end
      S_WR: begin
        O_PadDat     = I_WrDat;
        O_PadDatVld  = I_WrDatVld;
        O_PadDatLast = I_WrDatVld && cnt_last;
        O_WrDatRdy   = I_PadDatRdy;
        if (wr_beat && cnt_last) begin
          state_nxt = S_FNH;
        end
      end
      S_RD: begin
        // Last comes from the beat counter; pad Last is only cross-checked.
        O_RdDat     = I_PadDat;
        O_RdDatVld  = I_PadDatVld;
        O_RdDatLast = cnt_last;
        O_PadDatRdy = I_RdDatRdy;
        if (rd_beat && cnt_last) begin
          state_nxt = S_FNH;
        end
      end
      S_FNH: begin
        O_ReqDone = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_itf_dram_initiator.sv
// tb/tb_itf_dram_initiator.sv - self-checking bench for itf_dram_initiator with a behavioural DRAM
module tb_itf_dram_initiator;

  localparam int PW  = 128;
  localparam int AW  = 16;
  localparam int DAW = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_vld, req_wr;
  logic [DAW-1:0] req_addr;
  logic [AW-1:0]  req_num;
  logic           req_rdy, req_done;
  logic [PW-1:0]  wr_dat;
  logic           wr_dat_vld, wr_dat_rdy;
  logic [PW-1:0]  rd_dat;
  logic           rd_dat_vld, rd_dat_last, rd_dat_rdy;
  logic           dat_oe;
  logic [PW-1:0]  pad_dat_o;
  logic           pad_vld_o, pad_last_o;
  logic [PW-1:0]  pad_dat_i;
  logic           pad_vld_i, pad_last_i;
  logic           pad_rdy_o, pad_rdy_i;
  logic           last_err;

  always #5 clk = ~clk;

  itf_dram_initiator dut (
    .I_SysClk    (clk),
    .I_SysRst_n  (rst_n),
    .I_ReqVld    (req_vld),
    .I_ReqWr     (req_wr),
    .I_ReqAddr   (req_addr),
    .I_ReqNum    (req_num),
    .O_ReqRdy    (req_rdy),
    .O_ReqDone   (req_done),
    .I_WrDat     (wr_dat),
    .I_WrDatVld  (wr_dat_vld),
    .O_WrDatRdy  (wr_dat_rdy),
    .O_RdDat     (rd_dat),
    .O_RdDatVld  (rd_dat_vld),
    .O_RdDatLast (rd_dat_last),
    .I_RdDatRdy  (rd_dat_rdy),
    .O_DatOE     (dat_oe),
    .O_PadDat    (pad_dat_o),
    .O_PadDatVld (pad_vld_o),
    .O_PadDatLast(pad_last_o),
    .I_PadDat    (pad_dat_i),
    .I_PadDatVld (pad_vld_i),
    .I_PadDatLast(pad_last_i),
    .O_PadDatRdy (pad_rdy_o),
    .I_PadDatRdy (pad_rdy_i),
    .O_LastErr   (last_err)
  );

  typedef struct {
    bit        wr;
    int        addr;
    int        num;
    int        vld_pct;
    int        rdy_pct;
    int        bad_beat;
    bit        stall;
    int        data_base;
    bit        exp_err;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] dram_mem [0:1023];
  logic [PW-1:0] ref_mem  [0:1023];
  logic          exp_last_err;
  vec_t          vecs [$];

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0b exp=%0b", name, got, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_vld    = 1'b0;
    req_wr     = 1'b0;
    req_addr   = '0;
    req_num    = '0;
    wr_dat     = '0;
    wr_dat_vld = 1'b0;
    rd_dat_rdy = 1'b0;
    pad_dat_i  = '0;
    pad_vld_i  = 1'b0;
    pad_last_i = 1'b0;
    pad_rdy_i  = 1'b0;
  endtask

  function automatic logic [PW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_req(input vec_t r);
    logic [PW-1:0] exp_cmd;
    logic [PW-1:0] wdata;
    logic          vld, rdy, is_last, pad_last;
    int            beat, cyc, idx;
    bit            first;

    req_vld  = 1'b1;
    req_wr   = r.wr;
    req_addr = DAW'(r.addr);
    req_num  = AW'(r.num);
    #2;
    check_bit("req_rdy_idle", req_rdy, 1'b1);
    tick();
    req_vld  = 1'b0;
    req_addr = $urandom;
    req_num  = AW'($urandom);

    if (r.num != 0) begin
      exp_cmd = PW'(r.wr) | (PW'(r.addr) << 1) | (PW'(r.num) << (1 + DAW));
      first = 1'b1;
      cyc = 0;
      while (1) begin
        rdy        = ($urandom_range(99) < r.rdy_pct);
        pad_rdy_i  = rdy;
        wr_dat_vld = 1'b1;
        #2;
        if (first) begin
          check_word("cmd_word", pad_dat_o, exp_cmd);
          check_bit("cmd_vld", pad_vld_o, 1'b1);
          check_bit("cmd_last", pad_last_o, 1'b0);
          check_bit("cmd_oe", dat_oe, 1'b1);
          check_bit("cmd_no_wr_rdy", wr_dat_rdy, 1'b0);
          first = 1'b0;
        end
        tick();
        if (rdy) break;
        cyc++;
        if (cyc > 200) begin
          check_bit("cmd_timeout", 1'b0, 1'b1);
          break;
        end
      end

      beat = 0;
      cyc  = 0;
      wdata = (r.data_base != 0) ? PW'(r.data_base) : rand_word();
      while (beat < r.num) begin
        idx     = (r.addr + beat) & 1023;
        is_last = (beat == r.num - 1);
        vld     = ($urandom_range(99) < r.vld_pct);
        if (r.stall && cyc >= 1 && cyc <= 3) rdy = 1'b0;
        else if (r.stall) rdy = 1'b1;
        else rdy = ($urandom_range(99) < r.rdy_pct);
        if (r.wr) begin
          wr_dat_vld = vld;
          wr_dat     = vld ? wdata : rand_word();
          pad_rdy_i  = rdy;
          pad_vld_i  = 1'b0;
          #2;
          check_bit("wr_oe", dat_oe, 1'b1);
          check_bit("wr_pad_vld", pad_vld_o, vld);
          check_bit("wr_rdy", wr_dat_rdy, rdy);
          check_bit("wr_pad_last", pad_last_o, vld && is_last);
          if (vld) check_word("wr_pad_dat", pad_dat_o, wdata);
          if (vld && rdy) begin
            dram_mem[idx] = pad_dat_o;
            ref_mem[idx]  = wdata;
            beat++;
            wdata = (r.data_base != 0) ? PW'(r.data_base * (beat + 1)) : rand_word();
          end
        end else begin
          wr_dat_vld = 1'b0;
          pad_last   = vld && (is_last ^ (beat == r.bad_beat));
          pad_vld_i  = vld;
          pad_dat_i  = vld ? dram_mem[idx] : rand_word();
          pad_last_i = pad_last;
          rd_dat_rdy = rdy;
          #2;
          check_bit("rd_oe", dat_oe, 1'b0);
          check_bit("rd_vld", rd_dat_vld, vld);
          check_bit("rd_pad_rdy", pad_rdy_o, rdy);
          check_bit("rd_last", rd_dat_last, is_last);
          if (vld && rdy) begin
            check_word("rd_dat", rd_dat, ref_mem[idx]);
            if (pad_last != is_last) exp_last_err = 1'b1;
            beat++;
          end
        end
        tick();
        cyc++;
        if (cyc > 400) begin
          check_bit("burst_timeout", 1'b0, 1'b1);
          break;
        end
      end
    end

    idle_inputs();
    #2;
    check_bit("done_pulse", req_done, 1'b1);
    check_bit("done_oe", dat_oe, 1'b1);
    check_bit("done_no_rdy", req_rdy, 1'b0);
    check_bit("done_no_pad_vld", pad_vld_o, 1'b0);
    check_bit("last_err", last_err, exp_last_err);
    tick();
    #2;
    check_bit("done_single", req_done, 1'b0);
    check_bit("back_to_idle", req_rdy, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    for (int i = 0; i < 1024; i++) begin
      dram_mem[i] = rand_word();
      ref_mem[i]  = dram_mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      dram_mem[256 + i] = PW'(8'hA0 + i);
      ref_mem[256 + i]  = PW'(8'hA0 + i);
    end
    exp_last_err = 1'b0;

    //           wr  addr    num vld  rdy  bad stall base  err
    vecs.push_back('{1'b0, 'h100, 4, 100, 100, -1, 1'b0, 0,    1'b0});
    vecs.push_back('{1'b1, 'h200, 3, 50,  100, -1, 1'b0, 'h11, 1'b0});
    vecs.push_back('{1'b0, 'h200, 2, 100, 100, -1, 1'b1, 0,    1'b0});
    vecs.push_back('{1'b1, 'h050, 0, 100, 100, -1, 1'b0, 0,    1'b0});
    vecs.push_back('{1'b0, 'h010, 1, 70,  60,  -1, 1'b0, 0,    1'b0});
    vecs.push_back('{1'b1, 'h3F0, 1, 70,  60,  -1, 1'b0, 0,    1'b0});
    vecs.push_back('{1'b0, 'h100, 4, 100, 100, 2,  1'b0, 0,    1'b1});

    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check_bit("rst_oe", dat_oe, 1'b1);
    check_bit("rst_req_rdy", req_rdy, 1'b1);
    check_bit("rst_done", req_done, 1'b0);
    check_bit("rst_last_err", last_err, 1'b0);
    check_bit("rst_pad_vld", pad_vld_o, 1'b0);
    check_bit("rst_pad_rdy", pad_rdy_o, 1'b0);
    check_bit("rst_rd_vld", rd_dat_vld, 1'b0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      do_req(vecs[i]);
      check_bit("vec_last_err", last_err, vecs[i].exp_err);
    end
    check_word("wr_mem0", dram_mem['h200], PW'('h11));
    check_word("wr_mem1", dram_mem['h201], PW'('h22));
    check_word("wr_mem2", dram_mem['h202], PW'('h33));

    // Reset while the second beat of an eight-beat write is on the pad.
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 'h300; req_num = 8;
    tick();
    req_vld = 1'b0;
    pad_rdy_i = 1'b1;
    tick();
    wr_dat = PW'('h5A5A); wr_dat_vld = 1'b1;
    #2;
    dram_mem['h300] = pad_dat_o;
    ref_mem['h300]  = PW'('h5A5A);
    tick();
    wr_dat = PW'('h6B6B);
    #2;
    check_bit("mid_wr_vld", pad_vld_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_oe", dat_oe, 1'b1);
    check_bit("mid_rst_req_rdy", req_rdy, 1'b1);
    check_bit("mid_rst_no_pad_vld", pad_vld_o, 1'b0);
    check_bit("mid_rst_no_wr_rdy", wr_dat_rdy, 1'b0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    exp_last_err = 1'b0;
    tick();
    check_bit("post_rst_oe", dat_oe, 1'b1);
    check_bit("post_rst_req_rdy", req_rdy, 1'b1);
    check_bit("post_rst_last_err", last_err, 1'b0);
    v = '{1'b0, 'h300, 2, 100, 100, -1, 1'b0, 0, 1'b0};
    do_req(v);

    for (int n = 0; n < 25; n++) begin
      v.wr       = $urandom_range(1);
      v.addr     = $urandom_range(1000);
      v.num      = ($urandom_range(9) == 0) ? 0 : $urandom_range(8, 1);
      v.vld_pct  = $urandom_range(100, 30);
      v.rdy_pct  = $urandom_range(100, 30);
      v.bad_beat = -1;
      v.stall    = 1'b0;
      v.data_base = 0;
      v.exp_err  = 1'b0;
      do_req(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
